alu_control_stage: RTL and testbench

- Registered producer of the ALU's 4-bit operation code and operand selects.
- Sits at the decode/execute boundary of the RV32I pipeline. It takes decoded instruction fields (opcode, funct3, funct7) through a valid/ready handshake and holds one registered entry for execute.
- Supports downstream stalls and pipeline flush.
- Flags unsupported encodings so the core can raise an illegal-instruction trap.

---
 rtl/alu_control_stage.sv | 175 +++++++++++++++++
 tb/tb_alu_control_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_stage.sv
// alu_control_stage
//   Registered decode/execute boundary stage for an RV32I pipeline. Decodes
//   opcode/funct3/funct7 into a 4-bit ALU op plus operand A/B selects and
//   holds one entry behind a valid/ready handshake. Unsupported encodings are
//   captured as an entry with illegal_insn=1 and zeroed control fields.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid / in_ready       upstream handshake (in_ready = !out_valid || out_ready)
//   opcode, funct3, funct7    decoded instruction fields
//   flush                     drop held entry and any same-cycle input
//   out_valid / out_ready     downstream handshake
//   alu_control               ALU op code (0000 ADD ... 1010 JALR target)
//   a_sel                     00 rs1, 01 PC, 10 zero
//   b_sel                     00 rs2, 01 immediate, 10 constant 4
//   illegal_insn              held entry has an unsupported encoding
module alu_control_stage (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] alu_control,
  output logic [1:0] a_sel,
  output logic [1:0] b_sel,
  output logic       illegal_insn
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_JALR = 4'b1010;

  localparam logic [1:0] A_RS1  = 2'b00;
  localparam logic [1:0] A_PC   = 2'b01;
  localparam logic [1:0] A_ZERO = 2'b10;
  localparam logic [1:0] B_RS2  = 2'b00;
  localparam logic [1:0] B_IMM  = 2'b01;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Shared funct3 map for OP and OP-IMM; f3 000/101 alternates are patched in the decoder.
  function automatic logic [3:0] f3_base(input logic [2:0] f3);
    case (f3)
      3'b000:  f3_base = ALU_ADD;
      3'b001:  f3_base = ALU_SLL;
      3'b010:  f3_base = ALU_SLT;
      3'b011:  f3_base = ALU_SLTU;
      3'b100:  f3_base = ALU_XOR;
      3'b101:  f3_base = ALU_SRL;
      3'b110:  f3_base = ALU_OR;
      default: f3_base = ALU_AND;
    endcase
  endfunction

  logic [3:0] dec_op;
  logic [1:0] dec_a, dec_b;
  logic       dec_ill;

  always_comb begin
    dec_op  = ALU_ADD;
    dec_a   = A_RS1;
    dec_b   = B_RS2;
    dec_ill = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_op = f3_base(funct3);
        if (funct7 == F7_ALT && funct3 == 3'b000)      dec_op  = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101) dec_op  = ALU_SRA;
        else if (funct7 != F7_ZERO)                    dec_ill = 1'b1;
      end
      OPC_OPIMM: begin
        dec_op = f3_base(funct3);
        dec_b  = B_IMM;
        // funct7 is part of the immediate except for the shift encodings
        if (funct3 == 3'b001 && funct7 != F7_ZERO) dec_ill = 1'b1;
        if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT)        dec_op  = ALU_SRA;
          else if (funct7 != F7_ZERO)  dec_ill = 1'b1;
        end
      end
      OPC_LOAD, OPC_STORE: dec_b = B_IMM;
      OPC_BRANCH: begin
        case (funct3[2:1])
          2'b00:   dec_op  = ALU_SUB;
          2'b10:   dec_op  = ALU_SLT;
          2'b11:   dec_op  = ALU_SLTU;
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec_a = A_PC;
        dec_b = B_IMM;
      end
      OPC_JALR: begin
        dec_op  = ALU_JALR;
        dec_b   = B_IMM;
        dec_ill = (funct3 != 3'b000);
      end
      OPC_LUI: begin
        dec_a = A_ZERO;
        dec_b = B_IMM;
      end
      OPC_AUIPC: begin
        dec_a = A_PC;
        dec_b = B_IMM;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  logic       valid_q;
  logic [3:0] alu_q, alu_d;
  logic [1:0] a_q, a_d, b_q, b_d;
  logic       ill_q;
  logic       accept;

  // Illegal entries carry zeroed control fields.
  assign alu_d = dec_ill ? ALU_ADD : dec_op;
  assign a_d   = dec_ill ? A_RS1   : dec_a;
  assign b_d   = dec_ill ? B_RS2   : dec_b;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      alu_q   <= ALU_ADD;
      a_q     <= A_RS1;
      b_q     <= B_RS2;
      ill_q   <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      alu_q   <= alu_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ill_q   <= dec_ill;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid    = valid_q;
  assign alu_control  = alu_q;
  assign a_sel        = a_q;
  assign b_sel        = b_q;
  assign illegal_insn = ill_q;

endmodule

// File: tb/tb_alu_control_stage.sv
module tb_alu_control_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       flush, out_valid, out_ready;
  logic [3:0] alu_control;
  logic [1:0] a_sel, b_sel;
  logic       illegal_insn;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_control_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_control(alu_control),
    .a_sel(a_sel), .b_sel(b_sel), .illegal_insn(illegal_insn)
  );

  typedef struct packed {
    logic       ill;
    logic [3:0] op;
    logic [1:0] a;
    logic [1:0] b;
  } dec_t;

  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    dec_t       exp;
  } vec_t;

  // Reference decode, straight from the instruction-set rules.
  function automatic dec_t ref_dec(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    logic [3:0] f3map [8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    dec_t r;
    bit legal;
    r = '0;
    legal = 1;
    if (opc == 7'h33) begin
      legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
      r.op = (f7 == 7'h20) ? ((f3 == 0) ? 4'd1 : 4'd9) : f3map[f3];
    end else if (opc == 7'h13) begin
      legal = !(f3 == 1 && f7 != 0) && !(f3 == 5 && f7 != 0 && f7 != 7'h20);
      r.op = (f3 == 5 && f7 == 7'h20) ? 4'd9 : f3map[f3];
      r.b = 1;
    end else if (opc == 7'h03 || opc == 7'h23) begin
      r.b = 1;
    end else if (opc == 7'h63) begin
      legal = !(f3 == 2 || f3 == 3);
      r.op = (f3 < 2) ? 4'd1 : (f3 < 6) ? 4'd5 : 4'd6;
    end else if (opc == 7'h6F) begin
      r.a = 1; r.b = 1;
    end else if (opc == 7'h67) begin
      legal = (f3 == 0);
      r.op = 4'd10; r.b = 1;
    end else if (opc == 7'h37) begin
      r.a = 2; r.b = 1;
    end else if (opc == 7'h17) begin
      r.a = 1; r.b = 1;
    end else begin
      legal = 0;
    end
    if (!legal) r = '{ill: 1'b1, op: 4'd0, a: 2'd0, b: 2'd0};
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic fl, input logic ordy);
    in_valid = iv; opcode = opc; funct3 = f3; funct7 = f7; flush = fl; out_ready = ordy;
  endtask

  task automatic chk_out(input string name, input logic v, input dec_t d);
    chk({name, ".valid"}, out_valid, v);
    chk({name, ".dec"}, {illegal_insn, alu_control, a_sel, b_sel}, d);
  endtask

  localparam logic [6:0] OPCS [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

  vec_t vecs [10];
  bit   mv;
  dec_t md;

  initial begin
    vecs[0] = '{7'h33, 3'd0, 7'h00, '{1'b0, 4'd0,  2'd0, 2'd0}};
    vecs[1] = '{7'h33, 3'd7, 7'h00, '{1'b0, 4'd2,  2'd0, 2'd0}};
    vecs[2] = '{7'h13, 3'd2, 7'h55, '{1'b0, 4'd5,  2'd0, 2'd1}};
    vecs[3] = '{7'h63, 3'd5, 7'h00, '{1'b0, 4'd5,  2'd0, 2'd0}};
    vecs[4] = '{7'h17, 3'd3, 7'h11, '{1'b0, 4'd0,  2'd1, 2'd1}};
    vecs[5] = '{7'h6F, 3'd0, 7'h00, '{1'b0, 4'd0,  2'd1, 2'd1}};
    vecs[6] = '{7'h33, 3'd0, 7'h01, '{1'b1, 4'd0,  2'd0, 2'd0}};
    vecs[7] = '{7'h13, 3'd1, 7'h20, '{1'b1, 4'd0,  2'd0, 2'd0}};
    vecs[8] = '{7'h67, 3'd2, 7'h00, '{1'b1, 4'd0,  2'd0, 2'd0}};
    vecs[9] = '{7'h7F, 3'd0, 7'h00, '{1'b1, 4'd0,  2'd0, 2'd0}};

    rst = 1'b1;
    drive(0, 7'h0, 3'd0, 7'h0, 0, 0);
    repeat (2) @(negedge clk);
    chk_out("reset", 1'b0, '0);
    chk("reset.in_ready", in_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Reset asserted mid-stall
    drive(1, 7'h63, 3'd6, 7'h0, 0, 0);
    @(negedge clk);
    drive(0, 7'h0, 3'd0, 7'h0, 0, 0);
    chk_out("stall_pre_rst", 1'b1, '{1'b0, 4'd6, 2'd0, 2'd0});
    #2 rst = 1'b1;
    #1 chk_out("async_rst", 1'b0, '0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_release.in_ready", in_ready, 1);
    @(negedge clk);

    // Back-to-back accepts
    drive(1, 7'h33, 3'd0, 7'h20, 0, 1);
    @(negedge clk);
    chk_out("b2b_sub", 1'b1, '{1'b0, 4'd1, 2'd0, 2'd0});
    drive(1, 7'h13, 3'd5, 7'h20, 0, 1);
    @(negedge clk);
    chk_out("b2b_srai", 1'b1, '{1'b0, 4'd9, 2'd0, 2'd1});
    drive(0, 7'h0, 3'd0, 7'h0, 0, 1);
    @(negedge clk);
    chk("drain.valid", out_valid, 0);
    chk("drain.keep_data", alu_control, 9);

    // Stall with a pending LUI
    drive(1, 7'h63, 3'd6, 7'h0, 0, 0);
    @(negedge clk);
    chk_out("stall_cap", 1'b1, '{1'b0, 4'd6, 2'd0, 2'd0});
    drive(1, 7'h37, 3'd0, 7'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall.in_ready", in_ready, 0);
      @(negedge clk);
      chk_out("stall_hold", 1'b1, '{1'b0, 4'd6, 2'd0, 2'd0});
    end
    out_ready = 1'b1;
    #1 chk("unstall.in_ready", in_ready, 1);
    @(negedge clk);
    chk_out("lui", 1'b1, '{1'b0, 4'd0, 2'd2, 2'd1});

    // Flush with JALR offered the same cycle
    drive(1, 7'h67, 3'd0, 7'h0, 1, 1);
    #1 chk("flush.in_ready", in_ready, 1);
    @(negedge clk);
    chk_out("flush_drop", 1'b0, '{1'b0, 4'd0, 2'd2, 2'd1});
    flush = 1'b0;
    @(negedge clk);
    chk_out("jalr", 1'b1, '{1'b0, 4'd10, 2'd0, 2'd1});

    // Table-driven vectors, one per cycle
    foreach (vecs[i]) begin
      drive(1, vecs[i].opc, vecs[i].f3, vecs[i].f7, 0, 1);
      @(negedge clk);
      chk_out($sformatf("vec%0d", i), 1'b1, vecs[i].exp);
    end

    // Full sweep of opcode/funct3 with representative funct7 values
    foreach (OPCS[o]) begin
      for (int f3 = 0; f3 < 8; f3++) begin
        for (int k = 0; k < 3; k++) begin
          logic [6:0] f7v;
          f7v = (k == 0) ? 7'h00 : (k == 1) ? 7'h20 : 7'h01;
          drive(1, OPCS[o], f3[2:0], f7v, 0, 1);
          @(negedge clk);
          chk_out($sformatf("sweep_%h_%0d_%h", OPCS[o], f3, f7v), 1'b1, ref_dec(OPCS[o], f3[2:0], f7v));
        end
      end
    end

    // Random handshake traffic against a transaction-level model
    drive(0, 7'h0, 3'd0, 7'h0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mv = 0;
    md = '0;
    for (int c = 0; c < 400; c++) begin
      logic iv, fl, ordy;
      logic [6:0] opc, f7;
      logic [2:0] f3;
      iv   = ($urandom_range(3) != 0);
      fl   = ($urandom_range(9) == 0);
      ordy = ($urandom_range(2) != 0);
      opc  = ($urandom_range(7) == 0) ? 7'($urandom) : OPCS[$urandom_range(8)];
      f3   = 3'($urandom);
      case ($urandom_range(2))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      drive(iv, opc, f3, f7, fl, ordy);
      #1 chk("rand.in_ready", in_ready, !mv || ordy);
      if (fl) mv = 0;
      else if (iv && (!mv || ordy)) begin
        mv = 1;
        md = ref_dec(opc, f3, f7);
      end else if (ordy) mv = 0;
      @(negedge clk);
      chk_out("rand", mv, md);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
